// File: rtl/acumulador_somador_if.sv
// Sample and total handshakes of acumulador_somador.
// master = upstream/downstream side, slave = the accumulator.
interface acumulador_somador_if #(
    parameter int unsigned LARGURA_ENTRADA = 4,
    parameter int unsigned LARGURA_ACC     = 8
);
    logic [LARGURA_ENTRADA-1:0] entrada;
    logic                       entrada_valida;
    logic                       entrada_pronta;
    logic [LARGURA_ACC-1:0]     saida;
    logic                       saida_valida;
    logic                       saida_pronta;

    modport master (
        output entrada,
        output entrada_valida,
        output saida_pronta,
        input  entrada_pronta,
        input  saida,
        input  saida_valida
    );

    modport slave (
        input  entrada,
        input  entrada_valida,
        input  saida_pronta,
        output entrada_pronta,
        output saida,
        output saida_valida
    );
endinterface

// File: rtl/acumulador_somador.sv
// Sums N_AMOSTRAS handshaked samples into a wider accumulator and hands the total downstream.
// Optional ACUMULADOR_SATURACAO_EN: saturate on carry instead of wrapping.
module acumulador_somador #(
    parameter int unsigned LARGURA_ENTRADA = 4,
    parameter int unsigned LARGURA_ACC     = 8,
    parameter int unsigned N_AMOSTRAS      = 4,
    localparam int unsigned LARGURA_CONT   = $clog2(N_AMOSTRAS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    acumulador_somador_if.slave     bus,
    input  logic                    limpar,
    output logic [LARGURA_CONT-1:0] contagem,
    output logic                    estouro
);

    localparam int unsigned LARGURA_SOMA = LARGURA_ACC + 1;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] ACUMULA = 2'd1;
    localparam logic [1:0] ENTREGA = 2'd2;

    logic [1:0]              estado_q, estado_d;
    logic [LARGURA_ACC-1:0]  acc_q, acc_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic                    estouro_q, estouro_d;
    logic                    valida_q, valida_d;

    logic                    transferencia;
    logic [LARGURA_SOMA-1:0] soma;
    logic                    carry;
    logic [LARGURA_CONT-1:0] cont_inc;

    // Acceptance depends on state only, so upstream never sees a path from its own valid.
    assign bus.entrada_pronta = (estado_q != ENTREGA);
    assign transferencia      = bus.entrada_valida && bus.entrada_pronta;

    assign soma     = LARGURA_SOMA'(acc_q) + LARGURA_SOMA'(bus.entrada);
    assign carry    = soma[LARGURA_SOMA-1];
    assign cont_inc = cont_q + LARGURA_CONT'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        estado_d  = estado_q;
        acc_d     = acc_q;
        cont_d    = cont_q;
        estouro_d = estouro_q;
        valida_d  = 1'b0;

        if (limpar) begin
            // Abort wins over any simultaneous handshake.
            estado_d  = OCIOSO;
            acc_d     = '0;
            cont_d    = '0;
            estouro_d = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO, ACUMULA: begin
                    if (transferencia) begin
                        cont_d    = cont_inc;
                        estouro_d = estouro_q | carry;
`ifdef ACUMULADOR_SATURACAO_EN
                        // Once saturated, stay pinned at all-ones until the batch ends.
                        if (carry || estouro_q) begin
                            acc_d = '1;
                        end else begin
                            acc_d = soma[LARGURA_ACC-1:0];
                        end
`else
                        acc_d = soma[LARGURA_ACC-1:0];
`endif
                        if (cont_inc == LARGURA_CONT'(N_AMOSTRAS)) begin
                            estado_d = ENTREGA;
                        end else begin
                            estado_d = ACUMULA;
                        end
                    end
                end
                ENTREGA: begin
                    // Total and flag stay frozen until downstream takes them.
                    if (bus.saida_pronta) begin
                        estado_d  = OCIOSO;
                        acc_d     = '0;
                        cont_d    = '0;
                        estouro_d = 1'b0;
                    end
                end
                default: begin
                    estado_d  = OCIOSO;
                    acc_d     = '0;
                    cont_d    = '0;
                    estouro_d = 1'b0;
                end
            endcase
        end

        valida_d = (estado_d == ENTREGA);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cont_q    <= '0;
            estouro_q <= 1'b0;
            valida_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cont_q    <= cont_d;
            estouro_q <= estouro_d;
            valida_q  <= valida_d;
        end
    end

    assign bus.saida        = acc_q;
    assign bus.saida_valida = valida_q;
    assign contagem         = cont_q;
    assign estouro          = estouro_q;

endmodule

// File: tb/tb_acumulador_somador.sv
// Directed bench for acumulador_somador: default, narrow-accumulator and single-sample instances.
module tb_acumulador_somador;

    logic clk;
    logic rst_n;
    logic limpar_a, limpar_b, limpar_c;
    logic [2:0] contagem_a, contagem_b;
    logic [0:0] contagem_c;
    logic estouro_a, estouro_b, estouro_c;

    int checks;
    int erros;

    acumulador_somador_if #(.LARGURA_ENTRADA(4), .LARGURA_ACC(8)) if_a ();
    acumulador_somador_if #(.LARGURA_ENTRADA(4), .LARGURA_ACC(5)) if_b ();
    acumulador_somador_if #(.LARGURA_ENTRADA(4), .LARGURA_ACC(8)) if_c ();

    acumulador_somador #(.LARGURA_ENTRADA(4), .LARGURA_ACC(8), .N_AMOSTRAS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .limpar(limpar_a),
        .contagem(contagem_a), .estouro(estouro_a)
    );
    acumulador_somador #(.LARGURA_ENTRADA(4), .LARGURA_ACC(5), .N_AMOSTRAS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .limpar(limpar_b),
        .contagem(contagem_b), .estouro(estouro_b)
    );
    acumulador_somador #(.LARGURA_ENTRADA(4), .LARGURA_ACC(8), .N_AMOSTRAS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .limpar(limpar_c),
        .contagem(contagem_c), .estouro(estouro_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verificar(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s obtido=%0d esperado=%0d", tag, obtido, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    // Feeds four samples back-to-back into dut_a, checking the running count.
    task automatic lote_a(input logic [3:0] amostras [4]);
        for (int i = 0; i < 4; i++) begin
            if_a.entrada        = amostras[i];
            if_a.entrada_valida = 1'b1;
            ciclo();
            verificar("lote_a_contagem", 32'(contagem_a), 32'(i + 1));
        end
        if_a.entrada_valida = 1'b0;
    endtask

    logic [3:0] v_3579 [4];
    logic [3:0] v_1111 [4];
    logic [3:0] v_10   [4];
    logic [31:0] esperado_b;

    initial begin
        checks = 0;
        erros  = 0;
        v_3579 = '{4'd3, 4'd5, 4'd7, 4'd9};
        v_1111 = '{4'd1, 4'd1, 4'd1, 4'd1};
        v_10   = '{4'd10, 4'd0, 4'd0, 4'd0};

        rst_n = 1'b0;
        limpar_a = 1'b0; limpar_b = 1'b0; limpar_c = 1'b0;
        if_a.entrada = '0; if_a.entrada_valida = 1'b0; if_a.saida_pronta = 1'b0;
        if_b.entrada = '0; if_b.entrada_valida = 1'b0; if_b.saida_pronta = 1'b0;
        if_c.entrada = '0; if_c.entrada_valida = 1'b0; if_c.saida_pronta = 1'b0;

        #3;
        verificar("rst_saida",          32'(if_a.saida), 32'd0);
        verificar("rst_saida_valida",   32'(if_a.saida_valida), 32'd0);
        verificar("rst_contagem",       32'(contagem_a), 32'd0);
        verificar("rst_estouro",        32'(estouro_a), 32'd0);
        verificar("rst_entrada_pronta", 32'(if_a.entrada_pronta), 32'd1);
        #9 rst_n = 1'b1;
        ciclo();

        // Batch 3,5,7,9 with downstream always ready.
        if_a.saida_pronta = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_a.entrada        = v_3579[i];
            if_a.entrada_valida = 1'b1;
            ciclo();
            verificar("b1_contagem", 32'(contagem_a), 32'(i + 1));
            if (i < 3) verificar("b1_valida_cedo", 32'(if_a.saida_valida), 32'd0);
        end
        if_a.entrada_valida = 1'b0;
        verificar("b1_saida_valida", 32'(if_a.saida_valida), 32'd1);
        verificar("b1_saida",        32'(if_a.saida), 32'd24);
        verificar("b1_estouro",      32'(estouro_a), 32'd0);
        verificar("b1_pronta_baixo", 32'(if_a.entrada_pronta), 32'd0);
        ciclo();
        verificar("b1_pos_valida",   32'(if_a.saida_valida), 32'd0);
        verificar("b1_pos_contagem", 32'(contagem_a), 32'd0);
        verificar("b1_pos_pronta",   32'(if_a.entrada_pronta), 32'd1);

        // Backpressure: total held, nothing consumed while ENTREGA.
        if_a.saida_pronta = 1'b0;
        lote_a(v_3579);
        if_a.entrada        = 4'd1;
        if_a.entrada_valida = 1'b1;
        for (int i = 0; i < 5; i++) begin
            verificar("bp_entrada_pronta", 32'(if_a.entrada_pronta), 32'd0);
            verificar("bp_saida",          32'(if_a.saida), 32'd24);
            verificar("bp_saida_valida",   32'(if_a.saida_valida), 32'd1);
            verificar("bp_contagem",       32'(contagem_a), 32'd4);
            ciclo();
        end
        // Delivery edge must not also take the waiting sample.
        if_a.saida_pronta = 1'b1;
        ciclo();
        verificar("bp_sem_bypass_contagem", 32'(contagem_a), 32'd0);
        verificar("bp_sem_bypass_valida",   32'(if_a.saida_valida), 32'd0);
        if_a.entrada_valida = 1'b0;
        ciclo();

        // Abort mid-batch; the coincident sample is discarded.
        if_a.entrada = 4'd2; if_a.entrada_valida = 1'b1; ciclo();
        if_a.entrada = 4'd4; ciclo();
        verificar("lp_contagem_antes", 32'(contagem_a), 32'd2);
        if_a.entrada = 4'd6; limpar_a = 1'b1; ciclo();
        limpar_a = 1'b0; if_a.entrada_valida = 1'b0;
        verificar("lp_contagem", 32'(contagem_a), 32'd0);
        verificar("lp_estouro",  32'(estouro_a), 32'd0);
        verificar("lp_valida",   32'(if_a.saida_valida), 32'd0);
        lote_a(v_1111);
        verificar("lp_saida",    32'(if_a.saida), 32'd4);
        verificar("lp_saida_valida", 32'(if_a.saida_valida), 32'd1);
        ciclo();

        // Asynchronous reset mid-batch.
        if_a.entrada = 4'd5; if_a.entrada_valida = 1'b1; ciclo();
        if_a.entrada = 4'd6; ciclo();
        if_a.entrada_valida = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        verificar("ar_contagem", 32'(contagem_a), 32'd0);
        verificar("ar_saida",    32'(if_a.saida), 32'd0);
        verificar("ar_valida",   32'(if_a.saida_valida), 32'd0);
        verificar("ar_estouro",  32'(estouro_a), 32'd0);
        verificar("ar_pronta",   32'(if_a.entrada_pronta), 32'd1);
        #1 rst_n = 1'b1;
        ciclo();
        lote_a(v_10);
        verificar("ar_saida_lote", 32'(if_a.saida), 32'd10);
        ciclo();

        // Narrow accumulator: 15*4 = 60 overflows 5 bits on the third sample.
`ifdef ACUMULADOR_SATURACAO_EN
        esperado_b = 32'd31;
`else
        esperado_b = 32'd28;
`endif
        if_b.saida_pronta = 1'b0;
        if_b.entrada = 4'd15;
        if_b.entrada_valida = 1'b1;
        ciclo(); ciclo();
        verificar("ov_estouro_2", 32'(estouro_b), 32'd0);
        ciclo();
        verificar("ov_estouro_3", 32'(estouro_b), 32'd1);
        ciclo();
        if_b.entrada_valida = 1'b0;
        verificar("ov_saida",   32'(if_b.saida), esperado_b);
        verificar("ov_estouro", 32'(estouro_b), 32'd1);
        verificar("ov_valida",  32'(if_b.saida_valida), 32'd1);
        ciclo();
        verificar("ov_estouro_retido", 32'(estouro_b), 32'd1);
        if_b.saida_pronta = 1'b1;
        ciclo();
        verificar("ov_estouro_limpo", 32'(estouro_b), 32'd0);

        // Single-sample batches: each takes two cycles.
        if_c.saida_pronta = 1'b1;
        if_c.entrada = 4'd7;
        if_c.entrada_valida = 1'b1;
        verificar("n1_pronta_inicial", 32'(if_c.entrada_pronta), 32'd1);
        ciclo();
        if_c.entrada = 4'd8;
        verificar("n1_valida_7", 32'(if_c.saida_valida), 32'd1);
        verificar("n1_saida_7",  32'(if_c.saida), 32'd7);
        verificar("n1_pronta_7", 32'(if_c.entrada_pronta), 32'd0);
        verificar("n1_contagem", 32'(contagem_c), 32'd1);
        ciclo();
        verificar("n1_valida_pos7", 32'(if_c.saida_valida), 32'd0);
        verificar("n1_pronta_pos7", 32'(if_c.entrada_pronta), 32'd1);
        ciclo();
        if_c.entrada_valida = 1'b0;
        verificar("n1_valida_8", 32'(if_c.saida_valida), 32'd1);
        verificar("n1_saida_8",  32'(if_c.saida), 32'd8);
        verificar("n1_pronta_8", 32'(if_c.entrada_pronta), 32'd0);
        ciclo();
        verificar("n1_valida_fim", 32'(if_c.saida_valida), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
